// File: rtl/idli_sqi_ctrl_m.sv
// idli_sqi_ctrl_m: sequencer for the paired SQI memories (lo = data[7:0], hi = data[15:8])
// Switches both devices from SPI to SQI after reset, then arbitrates fetch (F) and
// load/store (D) requests, running each as a single-word SQI transaction.
// Ports:
//   i_sqi_gck, i_sqi_rst_n            clock, async active-low reset
//   i_sqi_f_req/f_addr, o_sqi_f_gnt/f_vld        fetch requester (read only)
//   i_sqi_d_req/d_wr/d_addr/d_wdata, o_sqi_d_gnt/d_done   load/store requester
//   o_sqi_rdata                       read data shared by both requesters
//   o_sqi_rdy                         init complete
//   o_sqi_cs, o_sqi_sck_en, o_sqi_sio_oe   shared chip select, SCK enable, SIO output enables
//   o_sqi_lo_sio/hi_sio, i_sqi_lo_sio/hi_sio   per-memory SIO buses
module idli_sqi_ctrl_m #(
    parameter logic [7:0] INIT_CMD     = 8'h38,
    parameter logic [7:0] RD_CMD       = 8'h03,
    parameter logic [7:0] WR_CMD       = 8'h02,
    parameter int         DUMMY_CYCLES = 2
) (
    input  logic        i_sqi_gck,
    input  logic        i_sqi_rst_n,
    input  logic        i_sqi_f_req,
    input  logic [15:0] i_sqi_f_addr,
    output logic        o_sqi_f_gnt,
    output logic        o_sqi_f_vld,
    input  logic        i_sqi_d_req,
    input  logic        i_sqi_d_wr,
    input  logic [15:0] i_sqi_d_addr,
    input  logic [15:0] i_sqi_d_wdata,
    output logic        o_sqi_d_gnt,
    output logic        o_sqi_d_done,
    output logic [15:0] o_sqi_rdata,
    output logic        o_sqi_rdy,
    output logic        o_sqi_cs,
    output logic        o_sqi_sck_en,
    output logic [3:0]  o_sqi_sio_oe,
    output logic [3:0]  o_sqi_lo_sio,
    output logic [3:0]  o_sqi_hi_sio,
    input  logic [3:0]  i_sqi_lo_sio,
    input  logic [3:0]  i_sqi_hi_sio
);
    typedef enum logic [3:0] {
        INIT_GAP, INIT_SHIFT, INIT_END, IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, END
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        sel_d, wr_q, ptr_d;
    logic [15:0] addr_q, wdata_q;
    logic [7:0]  cmd;
    logic [23:0] addr24;

    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            state       <= INIT_GAP;
            cnt         <= 3'd0;
            o_sqi_rdy   <= 1'b0;
            o_sqi_rdata <= 16'h0000;
            ptr_d       <= 1'b1;
            sel_d       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == INIT_END)
                o_sqi_rdy <= 1'b1;
            if (o_sqi_f_gnt || o_sqi_d_gnt) begin
                sel_d   <= o_sqi_d_gnt;
                wr_q    <= o_sqi_d_gnt && i_sqi_d_wr;
                addr_q  <= o_sqi_d_gnt ? i_sqi_d_addr : i_sqi_f_addr;
                wdata_q <= i_sqi_d_wdata;
                // pointer only moves when both requesters competed
                if (i_sqi_f_req && i_sqi_d_req)
                    ptr_d <= o_sqi_d_gnt;
            end
            // first read cycle fills the high nibbles of each byte, second the low
            if (state == RDATA)
                o_sqi_rdata <= cnt[0] ? {o_sqi_rdata[15:12], i_sqi_hi_sio, o_sqi_rdata[7:4], i_sqi_lo_sio}
                                      : {i_sqi_hi_sio, o_sqi_rdata[11:8], i_sqi_lo_sio, o_sqi_rdata[3:0]};
        end
    end

    always_comb begin
        state_nxt    = state;
        o_sqi_cs     = 1'b1;
        o_sqi_sck_en = 1'b0;
        o_sqi_sio_oe = 4'h0;
        o_sqi_lo_sio = 4'h0;
        o_sqi_hi_sio = 4'h0;
        o_sqi_f_gnt  = 1'b0;
        o_sqi_d_gnt  = 1'b0;
        o_sqi_f_vld  = 1'b0;
        o_sqi_d_done = 1'b0;
        cmd          = wr_q ? WR_CMD : RD_CMD;
        addr24       = {8'h00, addr_q};
        case (state)
            INIT_GAP: state_nxt = INIT_SHIFT;
            INIT_SHIFT: begin
                o_sqi_cs     = 1'b0;
                o_sqi_sck_en = 1'b1;
                o_sqi_sio_oe = 4'b0001;
                o_sqi_lo_sio = {3'b000, INIT_CMD[3'd7 - cnt]};
                o_sqi_hi_sio = {3'b000, INIT_CMD[3'd7 - cnt]};
                state_nxt    = (cnt == 3'd7) ? INIT_END : INIT_SHIFT;
            end
            INIT_END: state_nxt = IDLE;
            IDLE: begin
                o_sqi_f_gnt = o_sqi_rdy && i_sqi_f_req && (!i_sqi_d_req || ptr_d);
                o_sqi_d_gnt = o_sqi_rdy && i_sqi_d_req && (!i_sqi_f_req || !ptr_d);
                state_nxt   = (o_sqi_f_gnt || o_sqi_d_gnt) ? CMD : IDLE;
            end
            CMD: begin
                o_sqi_cs     = 1'b0;
                o_sqi_sck_en = 1'b1;
                o_sqi_sio_oe = 4'hF;
                o_sqi_lo_sio = cnt[0] ? cmd[3:0] : cmd[7:4];
                o_sqi_hi_sio = cnt[0] ? cmd[3:0] : cmd[7:4];
                state_nxt    = cnt[0] ? ADDR : CMD;
            end
            ADDR: begin
                o_sqi_cs     = 1'b0;
                o_sqi_sck_en = 1'b1;
                o_sqi_sio_oe = 4'hF;
                o_sqi_lo_sio = addr24[(5'd20 - {cnt, 2'b00}) +: 4];
                o_sqi_hi_sio = addr24[(5'd20 - {cnt, 2'b00}) +: 4];
                state_nxt    = (cnt == 3'd5) ? (wr_q ? WDATA : DUMMY) : ADDR;
            end
            DUMMY: begin
                o_sqi_cs     = 1'b0;
                o_sqi_sck_en = 1'b1;
                state_nxt    = (cnt == 3'(DUMMY_CYCLES - 1)) ? RDATA : DUMMY;
            end
            RDATA: begin
                o_sqi_cs     = 1'b0;
                o_sqi_sck_en = 1'b1;
                state_nxt    = cnt[0] ? END : RDATA;
            end
            WDATA: begin
                o_sqi_cs     = 1'b0;
                o_sqi_sck_en = 1'b1;
                o_sqi_sio_oe = 4'hF;
                o_sqi_lo_sio = cnt[0] ? wdata_q[3:0] : wdata_q[7:4];
                o_sqi_hi_sio = cnt[0] ? wdata_q[11:8] : wdata_q[15:12];
                state_nxt    = cnt[0] ? END : WDATA;
            end
            END: begin
                o_sqi_f_vld  = !sel_d;
                o_sqi_d_done = sel_d;
                state_nxt    = IDLE;
            end
            default: state_nxt = INIT_GAP;
        endcase
        cnt_nxt = (state_nxt == state) ? cnt + 3'd1 : 3'd0;
    end
endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// tb_idli_sqi_ctrl_m: scoreboard bench for idli_sqi_ctrl_m with a behavioural pair of SQI memories
module tb_idli_sqi_ctrl_m;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        f_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [15:0] f_addr = 16'h0, d_addr = 16'h0, d_wdata = 16'h0;
    logic [3:0]  lo_in = 4'h0, hi_in = 4'h0;
    logic        f_gnt, f_vld, d_gnt, d_done, rdy, cs, sck_en;
    logic [15:0] rdata;
    logic [3:0]  oe, lo_out, hi_out;

    typedef struct {
        bit          is_d;
        logic [7:0]  lat;
        logic [15:0] data;
    } exp_t;
    exp_t        sbq[$];
    logic [15:0] mem[logic [15:0]];
    logic [3:0]  cap_lo[0:15], cap_hi[0:15], cap_oe[0:15];
    int          cap_n = 0;
    bit          in_txn = 1'b0;
    int          n_cmp = 0, n_err = 0;
    logic [15:0] last_rd = 16'h0;

    idli_sqi_ctrl_m dut (
        .i_sqi_gck(clk), .i_sqi_rst_n(rst_n),
        .i_sqi_f_req(f_req), .i_sqi_f_addr(f_addr), .o_sqi_f_gnt(f_gnt), .o_sqi_f_vld(f_vld),
        .i_sqi_d_req(d_req), .i_sqi_d_wr(d_wr), .i_sqi_d_addr(d_addr), .i_sqi_d_wdata(d_wdata),
        .o_sqi_d_gnt(d_gnt), .o_sqi_d_done(d_done), .o_sqi_rdata(rdata), .o_sqi_rdy(rdy),
        .o_sqi_cs(cs), .o_sqi_sck_en(sck_en), .o_sqi_sio_oe(oe),
        .o_sqi_lo_sio(lo_out), .o_sqi_hi_sio(hi_out), .i_sqi_lo_sio(lo_in), .i_sqi_hi_sio(hi_in)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 16'hA5C3);
    endfunction

    function automatic logic [31:0] cap32(input bit h);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 8; i++) r = {r[27:0], h ? cap_hi[i] : cap_lo[i]};
        return r;
    endfunction

    // memory pair: records each SCK cycle, answers reads, stores writes; junk on the bus otherwise
    initial forever begin
        logic [15:0] a, w;
        @(negedge clk);
        lo_in = 4'($urandom);
        hi_in = 4'($urandom);
        if (cs) in_txn = 1'b0;
        else if (sck_en) begin
            if (!in_txn) begin in_txn = 1'b1; cap_n = 0; end
            if (cap_n < 16) begin cap_lo[cap_n] = lo_out; cap_hi[cap_n] = hi_out; cap_oe[cap_n] = oe; end
            if (cap_n >= 8) a = {cap_lo[4], cap_lo[5], cap_lo[6], cap_lo[7]};
            if ({cap_lo[0], cap_lo[1]} == 8'h03 && (cap_n == 10 || cap_n == 11)) begin
                w = mem_rd(a);
                lo_in = (cap_n == 10) ? w[7:4] : w[3:0];
                hi_in = (cap_n == 10) ? w[15:12] : w[11:8];
            end
            if ({cap_lo[0], cap_lo[1]} == 8'h02 && cap_n == 9) mem[a] = {cap_hi[8], hi_out, cap_lo[8], lo_out};
            cap_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        step;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic wait_gnt(output logic [7:0] w);
        w = 8'd0;
        while (!(f_gnt || d_gnt) && w < 8'd60) begin step; w++; end
    endtask

    task automatic wait_out(input bit drop_f, input bit drop_d, input logic [7:0] start, output logic [7:0] lat);
        lat = start;
        step;
        lat++;
        if (drop_f) f_req = 1'b0;
        if (drop_d) d_req = 1'b0;
        while (!(f_vld || d_done) && lat < 8'd60) begin step; lat++; end
    endtask

    task automatic test_reset;
        logic [10:0] cs_v, rdy_v, gnt_v;
        logic [7:0]  lo0, hi0, lat;
        bit          bad = 1'b0;
        exp_t        e;
        f_addr = 16'h0042; f_req = 1'b1; rst_n = 1'b0;
        step; step;
        n_cmp++;
        if ({cs, sck_en, oe, lo_out, hi_out, rdy, rdata, f_gnt, f_vld, d_gnt, d_done} !== {1'b1, 1'b0, 12'h0, 1'b0, 16'h0, 4'h0}) begin
            n_err++; $display("FAIL reset_outputs: got cs=%b sck=%b oe=%h rdy=%b rdata=%h gnt=%b exp cs=1 rest 0", cs, sck_en, oe, rdy, rdata, f_gnt);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) step;
            cs_v = {cs_v[9:0], cs}; rdy_v = {rdy_v[9:0], rdy}; gnt_v = {gnt_v[9:0], f_gnt};
            if (c >= 1 && c <= 8) begin
                lo0 = {lo0[6:0], lo_out[0]}; hi0 = {hi0[6:0], hi_out[0]};
                if ({oe, lo_out[3:1], hi_out[3:1], sck_en} !== {4'b0001, 6'b0, 1'b1}) bad = 1'b1;
            end
        end
        n_cmp++;
        if (cs_v !== 11'b10000000011) begin n_err++; $display("FAIL init_cs: got %b exp %b", cs_v, 11'b10000000011); end
        n_cmp++;
        if ({lo0, hi0} !== 16'h3838) begin n_err++; $display("FAIL init_cmd_bits: got lo=%h hi=%h exp 38/38", lo0, hi0); end
        n_cmp++;
        if (bad !== 1'b0) begin n_err++; $display("FAIL init_shift_bus: got bad oe/sio/sck got %b exp 0", bad); end
        n_cmp++;
        if ({rdy_v, gnt_v} !== {11'b1, 11'b1}) begin n_err++; $display("FAIL init_rdy_gnt: got rdy=%b gnt=%b exp 00000000001 both", rdy_v, gnt_v); end
        sbq.push_back('{1'b0, 8'd13, mem_rd(16'h0042)});
        wait_out(1'b1, 1'b0, 8'd0, lat);
        e = sbq.pop_front(); n_cmp++;
        if ({f_vld, d_done, lat, rdata} !== {!e.is_d, e.is_d, e.lat, e.data}) begin
            n_err++; $display("FAIL reset_first_read: got vld=%b done=%b lat=%0d rdata=%h exp lat=%0d rdata=%h", f_vld, d_done, lat, rdata, e.lat, e.data);
        end
        last_rd = e.data;
    endtask

    task automatic test_f_read;
        logic [7:0] w, lat;
        exp_t       e;
        mem[16'h1234] = 16'hABCD;
        f_addr = 16'h1234; f_req = 1'b1; #1;
        wait_gnt(w);
        n_cmp++;
        if ({f_gnt, d_gnt} !== 2'b10) begin n_err++; $display("FAIL f_read_gnt: got f=%b d=%b exp f=1 d=0", f_gnt, d_gnt); end
        sbq.push_back('{1'b0, 8'd13, 16'hABCD});
        wait_out(1'b1, 1'b0, 8'd0, lat);
        e = sbq.pop_front(); n_cmp++;
        if ({f_vld, d_done, lat, rdata} !== {!e.is_d, e.is_d, e.lat, e.data}) begin
            n_err++; $display("FAIL f_read_result: got vld=%b done=%b lat=%0d rdata=%h exp lat=%0d rdata=%h", f_vld, d_done, lat, rdata, e.lat, e.data);
        end
        last_rd = e.data;
        n_cmp++;
        if ({cap32(1'b0), cap32(1'b1)} !== {32'h03001234, 32'h03001234}) begin
            n_err++; $display("FAIL f_read_bus: got lo=%h hi=%h exp 03001234", cap32(1'b0), cap32(1'b1));
        end
        n_cmp++;
        if ({cap_oe[0], cap_oe[7], cap_oe[8], cap_oe[11], cap_n} !== {16'hFF00, 32'd12}) begin
            n_err++; $display("FAIL f_read_oe_len: got oe=%h%h%h%h n=%0d exp FF00 12", cap_oe[0], cap_oe[7], cap_oe[8], cap_oe[11], cap_n);
        end
    endtask

    task automatic test_d_write;
        logic [7:0] w, lat;
        exp_t       e;
        d_wr = 1'b1; d_addr = 16'hFFFF; d_wdata = 16'h5AC3; d_req = 1'b1; #1;
        wait_gnt(w);
        n_cmp++;
        if ({f_gnt, d_gnt} !== 2'b01) begin n_err++; $display("FAIL d_write_gnt: got f=%b d=%b exp f=0 d=1", f_gnt, d_gnt); end
        sbq.push_back('{1'b1, 8'd11, last_rd});
        wait_out(1'b0, 1'b1, 8'd0, lat);
        e = sbq.pop_front(); n_cmp++;
        if ({f_vld, d_done, lat, rdata} !== {!e.is_d, e.is_d, e.lat, e.data}) begin
            n_err++; $display("FAIL d_write_result: got vld=%b done=%b lat=%0d rdata=%h exp lat=%0d rdata=%h", f_vld, d_done, lat, rdata, e.lat, e.data);
        end
        n_cmp++;
        if ({cap32(1'b0), cap32(1'b1), cap_lo[8], cap_lo[9], cap_hi[8], cap_hi[9], cap_oe[8], cap_oe[9], cap_n}
            !== {32'h0200FFFF, 32'h0200FFFF, 8'hC3, 8'h5A, 8'hFF, 32'd10}) begin
            n_err++; $display("FAIL d_write_bus: got lo=%h hi=%h data lo=%h%h hi=%h%h oe=%h%h n=%0d exp 0200FFFF C3 5A FF 10",
                              cap32(1'b0), cap32(1'b1), cap_lo[8], cap_lo[9], cap_hi[8], cap_hi[9], cap_oe[8], cap_oe[9], cap_n);
        end
        d_wr = 1'b0;
    endtask

    task automatic test_arbitration;
        logic [7:0] w, lat;
        logic [2:0] order;
        logic [15:0] gaps;
        exp_t       e;
        do_reset;
        last_rd = 16'h0;
        f_addr = 16'h0100; d_addr = 16'h0200; d_wr = 1'b0; f_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(w);
            order = {order[1:0], d_gnt};
            if (k > 0) gaps = {gaps[7:0], w};
            sbq.push_back('{k == 1, 8'd13, mem_rd(k == 1 ? 16'h0200 : 16'h0100)});
            wait_out(1'b0, 1'b0, 8'd0, lat);
            e = sbq.pop_front(); n_cmp++;
            if ({f_vld, d_done, lat, rdata} !== {!e.is_d, e.is_d, e.lat, e.data}) begin
                n_err++; $display("FAIL arb_txn%0d: got vld=%b done=%b lat=%0d rdata=%h exp d=%b lat=%0d rdata=%h", k, f_vld, d_done, lat, rdata, e.is_d, e.lat, e.data);
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        n_cmp++;
        if ({order, gaps} !== {3'b010, 16'h0101}) begin n_err++; $display("FAIL arb_order: got order=%b gaps=%h exp 010 0101", order, gaps); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  w, lat;
        logic [15:0] old;
        exp_t        e;
        mem[16'h0020] = 16'h1234;
        d_wr = 1'b0; d_addr = 16'h0010; d_req = 1'b1; #1;
        wait_gnt(w);
        sbq.push_back('{1'b1, 8'd13, mem_rd(16'h0010)});
        wait_out(1'b0, 1'b1, 8'd0, lat);
        e = sbq.pop_front(); n_cmp++;
        if ({f_vld, d_done, lat, rdata} !== {!e.is_d, e.is_d, e.lat, e.data}) begin
            n_err++; $display("FAIL b2b_first: got vld=%b done=%b lat=%0d rdata=%h exp lat=%0d rdata=%h", f_vld, d_done, lat, rdata, e.lat, e.data);
        end
        old = e.data;
        d_addr = 16'h0020; d_req = 1'b1; #1;
        wait_gnt(w);
        n_cmp++;
        if ({f_gnt, d_gnt, w} !== {2'b01, 8'd1}) begin n_err++; $display("FAIL b2b_gap: got f=%b d=%b gap=%0d exp d=1 gap=1", f_gnt, d_gnt, w); end
        for (int i = 0; i < 11; i++) begin step; d_req = 1'b0; end
        n_cmp++;
        if (rdata !== old) begin n_err++; $display("FAIL b2b_hold: got %h exp %h", rdata, old); end
        step;
        n_cmp++;
        if (rdata !== {4'h1, old[11:8], 4'h3, old[3:0]}) begin n_err++; $display("FAIL b2b_partial: got %h exp %h", rdata, {4'h1, old[11:8], 4'h3, old[3:0]}); end
        sbq.push_back('{1'b1, 8'd13, 16'h1234});
        wait_out(1'b0, 1'b0, 8'd12, lat);
        e = sbq.pop_front(); n_cmp++;
        if ({f_vld, d_done, lat, rdata} !== {!e.is_d, e.is_d, e.lat, e.data}) begin
            n_err++; $display("FAIL b2b_second: got vld=%b done=%b lat=%0d rdata=%h exp lat=%0d rdata=%h", f_vld, d_done, lat, rdata, e.lat, e.data);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] w, lat, n;
        bit         vld_seen = 1'b0;
        exp_t       e;
        do_reset;
        f_addr = 16'h0777; f_req = 1'b1; #1;
        wait_gnt(w);
        step; f_req = 1'b0;
        step; step; step;
        n_cmp++;
        if ({cs, sck_en, oe} !== {1'b0, 1'b1, 4'hF}) begin n_err++; $display("FAIL mid_addr_phase: got cs=%b sck=%b oe=%h exp 0 1 F", cs, sck_en, oe); end
        f_addr = 16'h0888; f_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cs, sck_en, oe, rdy, f_vld} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL mid_async_reset: got cs=%b sck=%b oe=%h rdy=%b vld=%b exp 1 0 0 0 0", cs, sck_en, oe, rdy, f_vld);
        end
        step; step;
        @(negedge clk); rst_n = 1'b1; #1;
        n = 8'd0;
        while (!f_gnt && n < 8'd60) begin vld_seen |= f_vld; step; n++; end
        n_cmp++;
        if ({n, vld_seen} !== {8'd10, 1'b0}) begin n_err++; $display("FAIL mid_regrant: got cycles=%0d vld_seen=%b exp 10 0", n, vld_seen); end
        sbq.push_back('{1'b0, 8'd13, mem_rd(16'h0888)});
        wait_out(1'b1, 1'b0, 8'd0, lat);
        e = sbq.pop_front(); n_cmp++;
        if ({f_vld, d_done, lat, rdata} !== {!e.is_d, e.is_d, e.lat, e.data}) begin
            n_err++; $display("FAIL mid_read_result: got vld=%b done=%b lat=%0d rdata=%h exp lat=%0d rdata=%h", f_vld, d_done, lat, rdata, e.lat, e.data);
        end
    endtask

    initial begin
        test_reset;
        test_f_read;
        test_d_write;
        test_arbitration;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
